// File: rtl/nibble_swap_arbiter.sv
// Purpose : two-requester round-robin front end for an external nibble swapper.
// Latency : grant -> rsp_valid in SW_LAT+2 cycles; grant-to-grant period SW_LAT+3 cycles.
// Backpr. : response held in RESP until rsp_ready; requests wait (no grant) while busy.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   req0/data0/gnt0     : requester 0 (req held with data until gnt pulse)
//   req1/data1/gnt1     : requester 1
//   sw_swap/sw_data_in  : command and operand to the swapper
//   sw_data_out         : swapper result, valid SW_LAT cycles after sw_swap
//   rsp_valid/rsp_id/rsp_data/rsp_ready : response channel (valid/ready)
//   busy                : high whenever the FSM is not IDLE
//
// SW_LAT legal range is 1..7 (3-bit latency counter).

module nibble_swap_arbiter #(
    parameter int unsigned SW_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       sw_swap,
    output logic [7:0] sw_data_in,
    input  logic [7:0] sw_data_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       busy
);

    localparam logic [2:0] LAT = 3'(SW_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic [7:0] op_reg;
    logic       id_reg;
    logic       last_id;     // requester served most recently
    logic       pick1;       // arbitration result: 1 selects requester 1
    logic       take;        // a request is accepted this cycle
    logic       wait_done;   // last WAIT cycle

    // Requester 1 wins when alone, or when both request and 0 was served last.
    assign pick1     = req1 & (~req0 | ~last_id);
    assign take      = (state == IDLE) & (req0 | req1);
    assign wait_done = (state == WAIT) & (cnt == 3'd1);

    // Grants are combinational from req in IDLE; gating with rst keeps them
    // low during reset even though the state register already reads IDLE.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && take) begin
            gnt0 = ~pick1;
            gnt1 = pick1;
        end
    end

    assign sw_swap    = (state == ISSUE);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign sw_data_in = op_reg;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = LAT;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand and requester id latched at grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg <= 8'h00;
            id_reg <= 1'b0;
        end else if (take) begin
            op_reg <= pick1 ? data1 : data0;
            id_reg <= pick1;
        end
    end

    // Response capture at the edge ending the last WAIT cycle; these hold
    // their values until the next capture so the consumer can read them late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data <= 8'h00;
            rsp_id   <= 1'b0;
        end else if (wait_done) begin
            rsp_data <= sw_data_out;
            rsp_id   <= id_reg;
        end
    end

    // Round-robin pointer moves only when a response is actually consumed,
    // so an aborted transaction never counts as service. Reset value 1 makes
    // requester 0 win the first contended arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_id <= 1'b1;
        end else if ((state == RESP) && rsp_ready) begin
            last_id <= rsp_id;
        end
    end

endmodule

// File: tb/tb_nibble_swap_arbiter.sv
// Purpose : self-checking bench for nibble_swap_arbiter with a 1-cycle swapper model.
// Latency : expectations queued at grant, compared when rsp_valid is observed.
// Backpr. : exercises rsp_ready low in RESP and requests arriving while busy.

module tb_nibble_swap_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0;
    logic [7:0] data0;
    logic       gnt0;
    logic       req1;
    logic [7:0] data1;
    logic       gnt1;
    logic       sw_swap;
    logic [7:0] sw_data_in;
    logic [7:0] sw_data_out;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];   // {id, data}

    always #5 clk = ~clk;

    nibble_swap_arbiter #(.SW_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .data0       (data0),
        .gnt0        (gnt0),
        .req1        (req1),
        .data1       (data1),
        .gnt1        (gnt1),
        .sw_swap     (sw_swap),
        .sw_data_in  (sw_data_in),
        .sw_data_out (sw_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    // Swapper model, SW_LAT = 1
    always_ff @(posedge clk) begin
        if (sw_swap) begin
            sw_data_out <= {sw_data_in[3:0], sw_data_in[7:4]};
        end
    end

    function automatic logic [7:0] swap_nib(input logic [7:0] v);
        return {v[3:0], v[7:4]};
    endfunction

    task automatic test_reset();
        rst       = 1'b0;
        req0      = 1'b1;
        req1      = 1'b1;
        data0     = 8'hFF;
        data1     = 8'hEE;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, sw_swap, rsp_valid, busy} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000", {gnt0, gnt1, sw_swap, rsp_valid, busy});
        end else n_pass++;
        n_checks++;
        if ({sw_data_in, rsp_data, rsp_id} !== 17'h0) begin
            $display("FAIL reset_data: got %h/%h/%b want 00/00/0", sw_data_in, rsp_data, rsp_id);
        end else n_pass++;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [8:0] e;
        int         got;
        @(posedge clk); #1;
        req0  = 1'b1;
        data0 = 8'hAB;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            $display("FAIL single_gnt: got %b want 10", {gnt0, gnt1});
        end else n_pass++;
        exp_q.push_back({1'b0, swap_nib(8'hAB)});
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sw_swap, sw_data_in, busy, gnt0} !== {1'b1, 8'hAB, 1'b1, 1'b0}) begin
            $display("FAIL single_issue: got swap=%b in=%h busy=%b gnt0=%b want 1 ab 1 0",
                     sw_swap, sw_data_in, busy, gnt0);
        end else n_pass++;
        got = -1;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = c;
                break;
            end
        end
        n_checks++;
        if (got != 3) begin
            $display("FAIL single_latency: got %0d want 3", got);
        end else n_pass++;
        if (got > 0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL single_rsp: got unexpected response want none");
            end else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_data} !== e) begin
                    $display("FAIL single_rsp: got %b/%h want %b/%h", rsp_id, rsp_data, e[8], e[7:0]);
                end else n_pass++;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({busy, rsp_valid, rsp_data} !== {1'b0, 1'b0, 8'hBA}) begin
            $display("FAIL single_idle: got busy=%b vld=%b data=%h want 0 0 ba", busy, rsp_valid, rsp_data);
        end else n_pass++;
    endtask

    task automatic test_contention();
        logic [8:0] e;
        int         nresp;
        int         last_c;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'hF0;
        data1 = 8'h12;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back({1'b0, swap_nib(8'hF0)});
            else            exp_q.push_back({1'b1, swap_nib(8'h12)});
        end
        nresp  = 0;
        last_c = 0;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) begin
                n_checks++;
                $display("FAIL cont_excl: got gnt0=1 gnt1=1 want one-hot");
            end
            if (rsp_valid) begin
                n_checks++;
                e = exp_q.pop_front();
                if ({rsp_id, rsp_data} !== e) begin
                    $display("FAIL cont_rsp%0d: got %b/%h want %b/%h", nresp, rsp_id, rsp_data, e[8], e[7:0]);
                end else n_pass++;
                if (nresp > 0) begin
                    n_checks++;
                    if (c - last_c != 4) begin
                        $display("FAIL cont_period%0d: got %0d want 4", nresp, c - last_c);
                    end else n_pass++;
                end
                last_c = c;
                nresp++;
            end
        end
        n_checks++;
        if (nresp != 4) begin
            $display("FAIL cont_count: got %0d want 4", nresp);
            exp_q.delete();
        end else n_pass++;
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, gnt0, gnt1} !== 3'b000) begin
            $display("FAIL cont_idle: got %b want 000", {busy, gnt0, gnt1});
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        int         got;
        @(posedge clk); #1;
        req0      = 1'b1;
        data0     = 8'h5A;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            $display("FAIL bp_gnt: got %b want 10", {gnt0, gnt1});
        end else n_pass++;
        exp_q.push_back({1'b0, swap_nib(8'h5A)});
        @(posedge clk); #1;
        req0 = 1'b0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (got != 1) begin
            $display("FAIL bp_valid: got no rsp_valid want rsp_valid");
        end else n_pass++;
        // Five RESP cycles with rsp_ready low; requester 1 asks meanwhile.
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                req1  = 1'b1;
                data1 = 8'h9C;
                @(negedge clk);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data, gnt0, gnt1} !== {1'b1, 1'b0, 8'hA5, 1'b0, 1'b0}) begin
                $display("FAIL bp_hold%0d: got vld=%b id=%b data=%h gnt=%b%b want 1 0 a5 00",
                         k, rsp_valid, rsp_id, rsp_data, gnt0, gnt1);
            end else n_pass++;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        e = exp_q.pop_front();
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e}) begin
            $display("FAIL bp_rsp: got vld=%b %b/%h want 1 %b/%h", rsp_valid, rsp_id, rsp_data, e[8], e[7:0]);
        end else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({busy, gnt1, gnt0} !== 3'b010) begin
            $display("FAIL bp_idle: got busy=%b gnt1=%b gnt0=%b want 0 1 0", busy, gnt1, gnt0);
        end else n_pass++;
        exp_q.push_back({1'b1, swap_nib(8'h9C)});
        @(posedge clk); #1;
        req1 = 1'b0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        e = exp_q.pop_front();
        if (got != 1 || {rsp_id, rsp_data} !== e) begin
            $display("FAIL bp_next_rsp: got seen=%0d %b/%h want 1 %b/%h", got, rsp_id, rsp_data, e[8], e[7:0]);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] e;
        int         got;
        req1  = 1'b1;
        data1 = 8'h77;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1) begin
            $display("FAIL rmw_gnt: got %b want 1", gnt1);
        end else n_pass++;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, sw_swap, rsp_valid} !== 3'b100) begin
            $display("FAIL rmw_in_wait: got %b want 100", {busy, sw_swap, rsp_valid});
        end else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({sw_swap, busy, rsp_valid} !== 3'b000) begin
            $display("FAIL rmw_async: got %b want 000", {sw_swap, busy, rsp_valid});
        end else n_pass++;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                @(posedge clk); #1;
                rst = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                $display("FAIL rmw_abort%0d: got vld=%b busy=%b want 0 0", c, rsp_valid, busy);
            end else n_pass++;
        end
        @(posedge clk); #1;
        req1  = 1'b1;
        data1 = 8'h3C;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            $display("FAIL rmw_regnt: got %b want 01", {gnt0, gnt1});
        end else n_pass++;
        exp_q.push_back({1'b1, swap_nib(8'h3C)});
        @(posedge clk); #1;
        req1 = 1'b0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        e = exp_q.pop_front();
        if (got != 1 || {rsp_id, rsp_data} !== e) begin
            $display("FAIL rmw_rsp: got seen=%0d %b/%h want 1 %b/%h", got, rsp_id, rsp_data, e[8], e[7:0]);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_dropped();
        logic [8:0] e;
        int         got;
        req0  = 1'b1;
        data0 = 8'h4D;
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            $display("FAIL drop_gnt0: got %b want 10", {gnt0, gnt1});
        end else n_pass++;
        exp_q.push_back({1'b0, swap_nib(8'h4D)});
        @(posedge clk); #1;
        req0  = 1'b0;
        req1  = 1'b1;
        data1 = 8'hE7;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b0) begin
            $display("FAIL drop_busy_gnt1: got %b want 0", gnt1);
        end else n_pass++;
        @(posedge clk); #1;
        req1 = 1'b0;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt1) begin
                n_checks++;
                $display("FAIL drop_gnt1: got gnt1=1 want 0");
            end
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        e = exp_q.pop_front();
        if (got != 1 || {rsp_id, rsp_data} !== e) begin
            $display("FAIL drop_rsp: got seen=%0d %b/%h want 1 %b/%h", got, rsp_id, rsp_data, e[8], e[7:0]);
        end else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if ({gnt1, rsp_valid, busy} !== 3'b000) begin
                $display("FAIL drop_after%0d: got %b want 000", c, {gnt1, rsp_valid, busy});
            end else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drop_queue: got %0d pending want 0", exp_q.size());
        end else n_pass++;
    endtask

    initial begin
        rst       = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        data0     = 8'h00;
        data1     = 8'h00;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid_wait();
        test_dropped();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
